// File: rtl/njp_mult_pkg.sv
// Shared types and helpers for the njp sequential multiplier.
package njp_mult_pkg;

   // Controller state encoding.
   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StRun  = 2'b01,
      StDone = 2'b10
   } state_e;

   // Iteration counter width for a given operand width.
   function automatic int unsigned cnt_width(input int unsigned width);
      return $clog2(width);
   endfunction

endpackage

// File: rtl/njp_mult_ctrl.sv
// Control FSM and iteration counter for njp_seq_mult.
module njp_mult_ctrl
   import njp_mult_pkg::*;
#(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CntW  = cnt_width(WIDTH)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            start_i,
   output logic            busy_o,
   output logic            done_o,
   output logic            load_o,
   output logic            step_o,
   output logic            last_o,
   output logic [CntW-1:0] cnt_o
);

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   // State and counter registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic and strobes; start is only looked at in idle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy_o  = 1'b0;
      done_o  = 1'b0;
      load_o  = 1'b0;
      step_o  = 1'b0;
      last_o  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               state_d = StRun;
               cnt_d   = '0;
               load_o  = 1'b1;
            end
         end
         StRun: begin
            busy_o = 1'b1;
            step_o = 1'b1;
            if (cnt_q == CntW'(WIDTH - 1)) begin
               last_o  = 1'b1;
               state_d = StDone;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StDone: begin
            done_o  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/njp_seq_mult.sv
// Sequential shift-add multiplier with optional MAC.
// Build macro NJP_MULT_SIGNED_EN enables two's-complement operation via signed_mode.
module njp_seq_mult
   import njp_mult_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               acc,
   input  logic               signed_mode,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int unsigned PW   = 2 * WIDTH;
   localparam int unsigned CntW = cnt_width(WIDTH);

   logic            load, step, last;
   logic [CntW-1:0] cnt;
   logic [PW-1:0]   a_ext, partial, accum_nxt;
   logic [PW-1:0]   mcand_q, accum_q, product_q;
   logic [WIDTH-1:0] mplier_q;
   logic            sub_step;

   njp_mult_ctrl #(
      .WIDTH (WIDTH),
      .CntW  (CntW)
   ) u_ctrl (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .start_i (start),
      .busy_o  (busy),
      .done_o  (done),
      .load_o  (load),
      .step_o  (step),
      .last_o  (last),
      .cnt_o   (cnt)
   );

`ifdef NJP_MULT_SIGNED_EN
   logic signed_q;

   // Mode is latched with the operands so mid-run changes have no effect.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         signed_q <= 1'b0;
      end else if (load) begin
         signed_q <= signed_mode;
      end
   end

   assign a_ext    = signed_mode ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
   // The multiplier's sign bit carries negative weight.
   assign sub_step = signed_q & last;
`else
   logic unused_signed_mode;
   assign unused_signed_mode = signed_mode;
   assign a_ext    = {{WIDTH{1'b0}}, a};
   assign sub_step = 1'b0;
`endif

   assign partial = mcand_q << cnt;

   // One shift-add (or final subtract) step.
   always_comb begin
      accum_nxt = accum_q;
      if (mplier_q[cnt]) begin
         accum_nxt = sub_step ? (accum_q - partial) : (accum_q + partial);
      end
   end

   // Operand capture, accumulation and product update on the last step only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_q   <= '0;
         mplier_q  <= '0;
         accum_q   <= '0;
         product_q <= '0;
      end else if (load) begin
         mcand_q  <= a_ext;
         mplier_q <= b;
         accum_q  <= acc ? product_q : '0;
      end else if (step) begin
         accum_q <= accum_nxt;
         if (last) begin
            product_q <= accum_nxt;
         end
      end
   end

   assign product = product_q;

endmodule

// File: tb/tb_njp_seq_mult.sv
// Directed bench for njp_seq_mult (WIDTH=4) with an expected-result queue.
module tb_njp_seq_mult;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         acc = 1'b0;
   logic         signed_mode = 1'b0;
   logic         busy, done;
   logic [2*W-1:0] product;

   int total = 0;
   int bad   = 0;
   logic [2*W-1:0] exp_q[$];
   logic [2*W-1:0] cur_prod   = '0;  // model of product after all issued ops
   logic [2*W-1:0] shown_prod = '0;  // model of product currently visible
   int   bcycles;
   realtime t_first;

   njp_seq_mult #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .a           (a),
      .b           (b),
      .acc         (acc),
      .signed_mode (signed_mode),
      .busy        (busy),
      .done        (done),
      .product     (product)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [2*W-1:0] mul_model(input logic [W-1:0] x, input logic [W-1:0] y,
                                                 input logic sgn);
      int ix, iy;
      bit s;
`ifdef NJP_MULT_SIGNED_EN
      s = sgn;
`else
      s = 1'b0;
      if (sgn) s = 1'b0;
`endif
      if (s) begin
         ix = $signed(x);
         iy = $signed(y);
      end else begin
         ix = int'(x);
         iy = int'(y);
      end
      return (2*W)'(ix * iy);
   endfunction

   // Drive an operation at a negedge and record its expected result.
   task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic ac,
                        input logic sg);
      logic [2*W-1:0] e;
      a = x; b = y; acc = ac; signed_mode = sg; start = 1'b1;
      e = (ac ? cur_prod : '0) + mul_model(x, y, sg);
      exp_q.push_back(e);
      cur_prod = e;
   endtask

   task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic ac,
                         input logic sg);
      issue(x, y, ac, sg);
      @(negedge clk);
      start = 1'b0;
   endtask

   // Wait (bounded) for done, checking product stability while busy.
   task automatic wait_done(input string tag, input bit inject, output int nbusy);
      int guard = 0;
      nbusy = 0;
      while (!done && guard < 40) begin
         if (busy) begin
            nbusy++;
            check({tag, "_stable"}, {24'h0, product}, {24'h0, shown_prod});
            if (inject && nbusy == 2) begin
               a = 4'h3; b = 4'h3; start = 1'b1;
            end else if (inject && nbusy == 3) begin
               start = 1'b0;
            end
         end
         @(negedge clk);
         guard++;
      end
      check({tag, "_done_seen"}, {31'h0, done}, 32'h1);
      check({tag, "_no_overlap"}, {31'h0, busy}, 32'h0);
      if (exp_q.size() == 0) begin
         check({tag, "_queue"}, 32'h0, 32'h1);
      end else begin
         shown_prod = exp_q.pop_front();
         check({tag, "_product"}, {24'h0, product}, {24'h0, shown_prod});
      end
      @(negedge clk);
   endtask

   initial begin
      // Reset state
      #12;
      check("rst_product", {24'h0, product}, 32'h0);
      check("rst_busy", {31'h0, busy}, 32'h0);
      check("rst_done", {31'h0, done}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // 15*15 plain multiply, with latency and busy length
      launch(4'hF, 4'hF, 1'b0, 1'b0);
      wait_done("ff", 1'b0, bcycles);
      check("ff_busy_cycles", bcycles, W);
      check("ff_value", {24'h0, shown_prod}, 32'hE1);

      // MAC wrap: E1 + E1 mod 256
      launch(4'hF, 4'hF, 1'b1, 1'b0);
      wait_done("mac", 1'b0, bcycles);
      check("mac_busy_cycles", bcycles, W);

      // signed_mode request: honoured only when the macro is defined
      launch(4'hF, 4'h7, 1'b0, 1'b1);
      wait_done("sgn_f7", 1'b0, bcycles);
`ifdef NJP_MULT_SIGNED_EN
      check("sgn_f7_value", {24'h0, product}, 32'hF9);
      launch(4'h8, 4'h8, 1'b0, 1'b1);
      wait_done("sgn_88", 1'b0, bcycles);
      check("sgn_88_value", {24'h0, product}, 32'h40);
`else
      check("uns_f7_value", {24'h0, product}, 32'h69);
`endif

      // Start pulsed mid-run must be ignored and not queued
      launch(4'h5, 4'h6, 1'b0, 1'b0);
      wait_done("ign", 1'b1, bcycles);
      begin
         int extra = 0;
         for (int i = 0; i < 8; i++) begin
            if (done || busy) extra++;
            @(negedge clk);
         end
         check("ign_no_extra_op", extra, 0);
         check("ign_hold", {24'h0, product}, 32'h1E);
      end

      // Back-to-back with start held: one result per W+2 cycles
      issue(4'h2, 4'h5, 1'b0, 1'b0);
      issue(4'h2, 4'h5, 1'b0, 1'b0);
      @(negedge clk);
      wait_done("b2b1", 1'b0, bcycles);
      t_first = $realtime - 10.0;
      @(negedge clk);
      start = 1'b0;
      check("b2b_second_busy", {31'h0, busy}, 32'h1);
      wait_done("b2b2", 1'b0, bcycles);
      check("b2b_period", int'(($realtime - 10.0 - t_first) / 10.0), W + 2);

      // Reset aborts an operation in RUN
      launch(4'hF, 4'hF, 1'b0, 1'b0);
      wait_done("pre_rst", 1'b0, bcycles);
      launch(4'h5, 4'h6, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_product", {24'h0, product}, 32'h0);
      check("abort_busy", {31'h0, busy}, 32'h0);
      check("abort_done", {31'h0, done}, 32'h0);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      cur_prod   = '0;
      shown_prod = '0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("abort_no_resume", {30'h0, busy, done}, 32'h0);
      launch(4'h2, 4'h3, 1'b1, 1'b0);
      wait_done("post_rst", 1'b0, bcycles);
      check("post_rst_value", {24'h0, product}, 32'h06);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/njp_seq_mult.md
# njp_seq_mult

Parametrised sequential shift-add multiplier with a start/done handshake, optional multiply-accumulate, and compile-time two's-complement support. It multiplies two WIDTH-bit operands in WIDTH iterations into a 2·WIDTH-bit product register. It is the generalised successor of the fixed 4×4 multiplier datapath/control pair. It sits behind the tile's pin wrapper, which maps `ui_in` nibbles to `a`/`b` and `product` to `uo_out`.

## Interface
- `WIDTH`, default 4: operand width in bits, minimum 2; the product is 2·WIDTH bits.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request a new operation; sampled only in IDLE.
- `a` in WIDTH: multiplicand; captured on the accepted `start` edge.
- `b` in WIDTH: multiplier; captured on the accepted `start` edge.
- `acc` in 1: captured with `start`; 1 = add the result to the current `product` (MAC), 0 = plain multiply.
- `signed_mode` in 1: captured with `start`; 1 = two's-complement operands. Ignored unless the build macro is defined.
- `busy` out 1: high while in RUN.
- `done` out 1: one-cycle pulse when `product` has just been updated.
- `product` out 2·WIDTH: result register; holds its value until the next completion.

## Operation
- FSM states:
  - IDLE: `start`=1 → RUN. On this edge: latch `a`, `b`, `acc`, `signed_mode`; set cnt=0; set the accumulator to `product` if `acc`=1, otherwise 0.
  - RUN: each edge examines multiplier bit cnt and adds (multiplicand << cnt) to the accumulator when that bit is 1; cnt increments. The edge that processes cnt=WIDTH-1 writes the final accumulator to `product` and goes to DONE.
  - DONE: `done`=1 for exactly one cycle, then → IDLE unconditionally.
- `start` outside IDLE is ignored. It is not queued, and the latched operands are unaffected.
- Unsigned arithmetic: the multiplicand is zero-extended to 2·WIDTH bits.
- Signed arithmetic:
  - The multiplicand is sign-extended to 2·WIDTH bits.
  - At cnt=WIDTH-1, a multiplier bit of 1 subtracts the shifted multiplicand instead of adding it.
  - The result is the exact 2·WIDTH-bit two's-complement product.
- The accumulator is 2·WIDTH bits in both modes. MAC overflow wraps modulo 2^(2·WIDTH), with no saturation and no flag.
- Reset values: state IDLE, `busy`=0, `done`=0, `product`=0, cnt=0, accumulator=0.
- Reset asserted mid-RUN or mid-DONE aborts immediately. `product` returns to 0 and the operation is not resumed.

## Timing
- `start` accepted at edge E0 → `busy` high from E0 through edge E0+WIDTH.
- `product` valid and `done`=1 in the cycle after edge E0+WIDTH, i.e. latency WIDTH+1 edges from acceptance.
- `busy` and `done` are never high together.
- Back-to-back operations: `start` held high re-accepts at the edge leaving IDLE. The throughput is one result per WIDTH+2 cycles.
- `product` changes only on the completion edge, or to 0 on reset. It is stable otherwise, including while `busy`.

## Configuration
- `NJP_MULT_SIGNED_EN` defined:
  - The `signed_mode` port is honoured.
  - The signed extension and final-step subtract logic are compiled in.
- Not defined:
  - The port still exists but is ignored; all operations are unsigned.
  - No subtract path is synthesised.

## Structure
- Package `njp_mult_pkg`:
  - state typedef (IDLE, RUN, DONE) with its 2-bit encoding;
  - a helper constant for the counter width, `$clog2(WIDTH)`.
- One natural sub-module: `njp_mult_ctrl`, holding the FSM and iteration counter and emitting `busy`, `done`, a load strobe and a last-step strobe.
- The datapath (operand registers, accumulator, adder/subtractor) stays in the top module.

## Test plan
- WIDTH=4, unsigned, a=4'hF, b=4'hF, acc=0: `product`=8'hE1 with `done` exactly 5 edges after the start edge; `busy` high for 4 cycles.
- MAC wrap: following the previous case, start with acc=1, a=4'hF, b=4'hF: `product`=8'hC2 (0xE1+0xE1 mod 256).
- Signed mode with the macro defined:
  - a=4'h8, b=4'h8 (−8·−8) → 8'h40;
  - a=4'hF, b=4'h7 (−1·7) → 8'hF9.
- Macro undefined, signed_mode=1, a=4'hF, b=4'h7: `product`=8'h69 (unsigned 15·7).
- Second `start` with a=4'h3, b=4'h3 pulsed mid-RUN of a 4'h5×4'h6 operation: `product`=8'h1E, with a single `done` pulse.
- Reset asserted 2 cycles into RUN after a prior result of 8'hE1: `product`, `busy` and `done` all read 0 immediately; a following 4'h2×4'h3 operation yields 8'h06.
